// File: rtl/fin_edge_meter.sv
// Counts synchronized rising edges of fin over a win_len-cycle window; result via valid/ready.
// Define FIN_BOTH_EDGE_EN to count both rising and falling edges.
module fin_edge_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WIN_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fin,
   input  logic [WIN_W-1:0] win_len,
   input  logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             overflow
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_HOLD
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   fin_s;
   logic                   fin_d_q;
   logic                   edge_p;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;

   assign fin_s = sync_q[SYNC_STAGES-1];

`ifdef FIN_BOTH_EDGE_EN
   assign edge_p = fin_s ^ fin_d_q;
`else
   assign edge_p = fin_s & ~fin_d_q;
`endif

   // Synchronizer and edge history run in every state so a window starts with settled history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         fin_d_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], fin};
         fin_d_q <= fin_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               win_d   = win_len;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (win_len == '0) ? ST_HOLD : ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            win_d = win_q - WIN_W'(1);
            if (edge_p) begin
               // Overflow marks an edge lost because the count was already full.
               if (&cnt_q) ovf_d = 1'b1;
               else        cnt_d = cnt_q + CNT_W'(1);
            end
            if (win_q == WIN_W'(1)) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign cnt_valid = (state_q == ST_HOLD);
   assign cnt_out   = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fin_edge_meter.sv
// Self-checking bench for fin_edge_meter: table-driven windows, random windows, reset corners.
// A 16-bit and a 4-bit counter instance share stimulus; one edge-count model predicts both.
module tb_fin_edge_meter;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned WIN_W = 16;
   localparam int unsigned S     = 2;
   localparam int unsigned HMAX  = 16384;
`ifdef FIN_BOTH_EDGE_EN
   localparam int unsigned MUL = 2;
`else
   localparam int unsigned MUL = 1;
`endif

   logic             clk;
   logic             rst_n;
   logic             fin;
   logic [WIN_W-1:0] win_len;
   logic             start;
   logic             cnt_ready;
   logic             busy16, valid16, ovf16;
   logic [CNT_W-1:0] cnt16;
   logic             busy4, valid4, ovf4;
   logic [3:0]       cnt4;

   fin_edge_meter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(S)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .fin(fin), .win_len(win_len), .start(start),
      .busy(busy16), .cnt_out(cnt16), .cnt_valid(valid16), .cnt_ready(cnt_ready),
      .overflow(ovf16)
   );

   fin_edge_meter #(.CNT_W(4), .WIN_W(WIN_W), .SYNC_STAGES(S)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .fin(fin), .win_len(win_len), .start(start),
      .busy(busy4), .cnt_out(cnt4), .cnt_valid(valid4), .cnt_ready(cnt_ready),
      .overflow(ovf4)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;
   logic        hist [HMAX];

   int unsigned fin_mode = 0;  // 0 constant, 1 square wave, 2 random
   int unsigned fin_per  = 8;
   logic        fin_val  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // fin as the DUT sees it at each posedge; the synchronizer holds zero while in reset.
   always @(posedge clk) begin
      if (cyc < HMAX) hist[cyc] <= rst_n ? fin : 1'b0;
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      case (fin_mode)
         0:       fin = fin_val;
         1:       fin = ((cyc / (fin_per / 2)) % 2) == 1;
         default: fin = ($urandom_range(0, 1) == 1);
      endcase
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // A counted edge in the interval after posedge k compares fin sampled S and S-1 posedges earlier.
   function automatic int unsigned edge_at(input int unsigned k);
      logic a, b;
      a = hist[k - S];
      b = hist[k - S + 1];
`ifdef FIN_BOTH_EDGE_EN
      return (a != b) ? 1 : 0;
`else
      return (!a && b) ? 1 : 0;
`endif
   endfunction

   task automatic run_window(input int unsigned w, input int unsigned hold, input bit poke,
                             input int unsigned lo, input int unsigned hi);
      int unsigned      p0, n, e;
      logic [CNT_W-1:0] held16;
      logic [3:0]       held4;
      @(negedge clk);
      win_len = WIN_W'(w);
      start   = 1'b1;
      p0      = cyc;
      @(negedge clk);
      start   = 1'b0;
      win_len = WIN_W'($urandom);
      chk("busy_rise", 32'(busy16), 32'd1);
      n = 1;
      while (!valid16 && n < w + 8) begin
         start = (poke && w >= 4 && n == w / 2);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("valid_cycle", n, w + 1);
      e = 0;
      for (int unsigned k = p0; k < p0 + w; k++) e += edge_at(k);
      chk("cnt16", 32'(cnt16), (e < 65535) ? e : 65535);
      chk("ovf16", 32'(ovf16), (e > 65535) ? 1 : 0);
      chk("cnt4", 32'(cnt4), (e < 15) ? e : 15);
      chk("ovf4", 32'(ovf4), (e > 15) ? 1 : 0);
      chk("valid4", 32'(valid4), 32'd1);
      checks++;
      if (32'(cnt16) < lo || 32'(cnt16) > hi) begin
         errors++;
         $display("FAIL cnt_range: got %0d expected %0d..%0d", cnt16, lo, hi);
      end
      held16 = cnt16;
      held4  = cnt4;
      for (int unsigned i = 0; i < hold; i++) begin
         start = (i == 0);
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid", 32'(valid16), 32'd1);
         chk("hold_cnt", 32'(cnt16), 32'(held16));
         chk("hold_cnt4", 32'(cnt4), 32'(held4));
      end
      cnt_ready = 1'b1;
      @(negedge clk);
      cnt_ready = 1'b0;
      chk("accept_valid", 32'(valid16), 32'd0);
      chk("accept_busy", 32'(busy16), 32'd0);
      chk("accept_keep", 32'(cnt16), 32'(held16));
      @(negedge clk);
      chk("idle_busy", 32'(busy16), 32'd0);
   endtask

   typedef struct {
      int unsigned w;
      int unsigned mode;
      int unsigned per;
      logic        val;
      int unsigned hold;
      bit          poke;
      int unsigned lo;
      int unsigned hi;
   } vec_t;

   vec_t tbl [7];

   initial begin
      bit seen;
      tbl[0] = '{w: 64,  mode: 1, per: 8, val: 1'b0, hold: 0,  poke: 1'b1, lo: 8*MUL-1,  hi: 8*MUL+1};
      tbl[1] = '{w: 0,   mode: 1, per: 4, val: 1'b0, hold: 3,  poke: 1'b0, lo: 0,        hi: 0};
      tbl[2] = '{w: 40,  mode: 1, per: 6, val: 1'b0, hold: 20, poke: 1'b0, lo: 6*MUL,    hi: 7*MUL};
      tbl[3] = '{w: 100, mode: 1, per: 2, val: 1'b0, hold: 0,  poke: 1'b1, lo: 50*MUL-1, hi: 50*MUL+1};
      tbl[4] = '{w: 1,   mode: 0, per: 2, val: 1'b0, hold: 1,  poke: 1'b0, lo: 0,        hi: 0};
      tbl[5] = '{w: 30,  mode: 2, per: 2, val: 1'b0, hold: 2,  poke: 1'b1, lo: 0,        hi: 30*MUL};
      tbl[6] = '{w: 20,  mode: 1, per: 4, val: 1'b0, hold: 2,  poke: 1'b0, lo: 5*MUL-1,  hi: 5*MUL+1};

      rst_n     = 1'b0;
      start     = 1'b0;
      cnt_ready = 1'b0;
      win_len   = '0;
      fin       = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_busy", 32'(busy16), 32'd0);
      chk("rst_valid", 32'(valid16), 32'd0);
      chk("rst_cnt", 32'(cnt16), 32'd0);
      chk("rst_ovf", 32'(ovf16), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int unsigned i = 0; i < 7; i++) begin
         fin_mode = tbl[i].mode;
         fin_per  = tbl[i].per;
         fin_val  = tbl[i].val;
         run_window(tbl[i].w, tbl[i].hold, tbl[i].poke, tbl[i].lo, tbl[i].hi);
      end

      // Reset in cycle 30 of a 64-cycle window discards the measurement.
      fin_mode = 1;
      fin_per  = 8;
      @(negedge clk);
      win_len = 16'd64;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy16), 32'd0);
      chk("midrst_valid", 32'(valid16), 32'd0);
      chk("midrst_cnt", 32'(cnt16), 32'd0);
      chk("midrst_cnt4", 32'(cnt4), 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (valid16 || busy16) seen = 1'b1;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
      run_window(64, 0, 1'b0, 8*MUL-1, 8*MUL+1);

      // fin held high through reset release.
      fin_mode = 0;
      fin_val  = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      run_window(20, 0, 1'b0, 0, 1);
      run_window(20, 0, 1'b0, 0, 0);

      for (int unsigned r = 0; r < 12; r++) begin
         fin_mode = $urandom_range(1, 2);
         fin_per  = 2 * $urandom_range(1, 5);
         run_window($urandom_range(0, 50), $urandom_range(0, 4), $urandom_range(0, 1) == 1,
                    0, 32'hFFFF_FFFF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
